alu_seq_hs: RTL and testbench
=============================

// Module: alu_seq_hs
// PURPOSE
//  Parametrised successor to the single-cycle 8-bit ALU: WIDTH-bit operands, valid/ready handshake on both sides.
//  Iterative shift-add multiplier gives a full 2*WIDTH product; CARRY and ZERO flags are added.
//  Sits between the operand/instruction sequencer and the result register file; one operation in flight at a time.
// PARAMETERS
//  WIDTH  8  operand/result width in bits, legal range 4..32
// PORTS
//  CLK            in   1        system clock, rising edge
//  RESET          in   1        asynchronous, active-high reset
//  IN_VALID       in   1        operands/opcode presented
//  IN_READY       out  1        block can accept an operation
//  IN_A           in   WIDTH    operand A
//  IN_B           in   WIDTH    operand B
//  ALU_OP_CODE    in   4        operation select
//  OUT_VALID      out  1        result/flags valid
//  OUT_READY      in   1        consumer takes result
//  OUT_RESULT     out  WIDTH    result (low half for multiply)
//  OUT_RESULT_HI  out  WIDTH    upper product half for op 2, else 0
//  OUT_CARRY      out  1        carry/borrow/shifted-out bit
//  OUT_ZERO       out  1        1 when OUT_RESULT == 0 (and OUT_RESULT_HI == 0 for op 2)
// BEHAVIOUR
//  Reset: async, active-high; state=IDLE, IN_READY=1, OUT_VALID=0, all data/flag outputs=0.
//  - RESET asserted mid-multiply or in DONE aborts the operation; no result is ever presented.
//  FSM: IDLE -> (accept, op!=2) -> DONE; IDLE -> (accept, op==2) -> MUL; MUL -> (count==WIDTH-1) -> DONE;
//   DONE -> (OUT_READY) -> IDLE.
//  - Accept = IN_VALID & IN_READY.
//  - IN_READY = (state==IDLE); combinational from state only.
//  - A, B and opcode are captured on accept; input changes after accept have no effect.
//  Latency: single-cycle ops give OUT_VALID the cycle after accept. Multiply gives OUT_VALID WIDTH+1 cycles after accept.
//  - Minimum issue interval is 2 cycles (IN_READY low while in DONE).
//  DONE: OUT_VALID=1 and all outputs held stable until OUT_READY=1 is sampled.
//  - OUT_VALID drops the cycle after the handshake; outputs keep their last value (don't-care).
//  - OUT_READY outside DONE is ignored.
//  Opcodes (all arithmetic mod 2^WIDTH; CARRY=0 unless stated):
//  - 0 A+B (CARRY=carry out)      1 A-B (CARRY=borrow, A<B)      2 A*B unsigned, {HI,RESULT}
//  - 3 A<<1 (CARRY=A[MSB])        4 A>>1 logical (CARRY=A[0])    5 A+1 (CARRY=A all-ones)
//  - 6 B+1 (CARRY=B all-ones)     7 A-1 (CARRY=A==0)             8 B-1 (CARRY=B==0)
//  - 9 A==B  A A>B  B A<B unsigned; result = 1 or 0, zero-extended
//  - C A&B   D A|B   E A^B   F pass A
//  Multiplier: WIDTH iterations, one bit of B per cycle, LSB first.
//  - Each iteration adds A shifted into a 2*WIDTH accumulator; no early termination.
//  OUT_RESULT_HI = 0 for every op other than 2.
// TESTING (WIDTH=8 unless noted)
//  - Reset: assert RESET asynchronously mid-cycle -> IN_READY=1, OUT_VALID=0, outputs 0 with no clock edge.
//  - Add/flags: A=8'hFF,B=8'h01,op0 -> next cycle OUT_VALID=1, RESULT=00, CARRY=1, ZERO=1.
//    A=05,B=07,op1 -> RESULT=FE, CARRY=1.
//  - Multiply: A=8'hFF,B=8'hFF,op2 -> OUT_VALID exactly 9 cycles after accept, HI=FE, RESULT=01, ZERO=0.
//    IN_READY=0 throughout.
//  - Backpressure: hold OUT_READY=0 for 5 cycles after OUT_VALID -> outputs stable, IN_READY=0.
//    New IN_VALID not taken; OUT_READY=1 -> IDLE next cycle.
//  - Abort: assert RESET 3 cycles into a multiply -> no OUT_VALID.
//    Subsequent op9 A=3,B=3 -> RESULT=01.
//  - Sweep: WIDTH=16, random A/B over all 16 opcodes vs reference model; includes A=0, B=0, all-ones, shifts of MSB/LSB.

Source files
------------

// File: rtl/alu_seq_hs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_seq_hs                                                      |
// | Purpose  : WIDTH-bit sequential ALU with valid/ready handshakes on both    |
// |            sides. Single-cycle ops complete the cycle after accept. The    |
// |            multiply (op 2) is an iterative shift-add that takes one bit of |
// |            B per cycle, LSB first, and gives a full 2*WIDTH product.       |
// |            Only one operation is in flight at a time.                      |
// | Ports    : CLK, RESET        clock, asynchronous active-high reset         |
// |            IN_VALID/IN_READY input handshake, IN_READY = (state == IDLE)  |
// |            IN_A, IN_B        WIDTH-bit operands                            |
// |            ALU_OP_CODE       4-bit operation select                        |
// |            OUT_VALID/OUT_READY output handshake, OUT_VALID = (state==DONE)|
// |            OUT_RESULT        result, low product half for op 2             |
// |            OUT_RESULT_HI     high product half for op 2, else 0            |
// |            OUT_CARRY         carry / borrow / shifted-out bit              |
// |            OUT_ZERO          result (and high half for op 2) is zero       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module alu_seq_hs #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_A,
  input  logic [WIDTH-1:0] IN_B,
  input  logic [3:0]       ALU_OP_CODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_RESULT,
  output logic [WIDTH-1:0] OUT_RESULT_HI,
  output logic             OUT_CARRY,
  output logic             OUT_ZERO
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_SHL  = 4'h3;
  localparam logic [3:0] OP_SHR  = 4'h4;
  localparam logic [3:0] OP_INCA = 4'h5;
  localparam logic [3:0] OP_INCB = 4'h6;
  localparam logic [3:0] OP_DECA = 4'h7;
  localparam logic [3:0] OP_DECB = 4'h8;
  localparam logic [3:0] OP_EQ   = 4'h9;
  localparam logic [3:0] OP_GT   = 4'hA;
  localparam logic [3:0] OP_LT   = 4'hB;
  localparam logic [3:0] OP_AND  = 4'hC;
  localparam logic [3:0] OP_OR   = 4'hD;
  localparam logic [3:0] OP_XOR  = 4'hE;
  localparam logic [3:0] OP_PASS = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;   // A, shifted left once per iteration
  logic [WIDTH-1:0]     mplier_q, mplier_d; // B, shifted right; bit 0 is the current bit
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;

  logic                 accept;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_carry;
  logic [WIDTH:0]       sum_ext;
  logic [2*WIDTH-1:0]   acc_next;

  assign IN_READY      = (state_q == S_IDLE);
  assign OUT_VALID     = (state_q == S_DONE);
  assign OUT_RESULT    = res_q;
  assign OUT_RESULT_HI = hi_q;
  assign OUT_CARRY     = carry_q;
  assign OUT_ZERO      = zero_q;

  assign accept = IN_VALID & IN_READY;

  // Partial product for the current multiplier bit.
  assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Single-cycle datapath, evaluated directly on the live inputs; its
  // outputs are only captured on the accept edge.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    sum_ext   = '0;
    case (ALU_OP_CODE)
      OP_ADD: begin
        sum_ext   = {1'b0, IN_A} + {1'b0, IN_B};
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      OP_SUB: begin
        alu_res   = IN_A - IN_B;
        alu_carry = (IN_A < IN_B);
      end
      OP_SHL: begin
        alu_res   = {IN_A[WIDTH-2:0], 1'b0};
        alu_carry = IN_A[WIDTH-1];
      end
      OP_SHR: begin
        alu_res   = {1'b0, IN_A[WIDTH-1:1]};
        alu_carry = IN_A[0];
      end
      OP_INCA: begin
        alu_res   = IN_A + WIDTH'(1);
        alu_carry = &IN_A;
      end
      OP_INCB: begin
        alu_res   = IN_B + WIDTH'(1);
        alu_carry = &IN_B;
      end
      OP_DECA: begin
        alu_res   = IN_A - WIDTH'(1);
        alu_carry = (IN_A == '0);
      end
      OP_DECB: begin
        alu_res   = IN_B - WIDTH'(1);
        alu_carry = (IN_B == '0);
      end
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (IN_A == IN_B)};
      OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, (IN_A > IN_B)};
      OP_LT:   alu_res = {{(WIDTH-1){1'b0}}, (IN_A < IN_B)};
      OP_AND:  alu_res = IN_A & IN_B;
      OP_OR:   alu_res = IN_A | IN_B;
      OP_XOR:  alu_res = IN_A ^ IN_B;
      OP_PASS: alu_res = IN_A;
      default: ; // OP_MUL is produced by the iterative path
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    hi_d     = hi_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (ALU_OP_CODE == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, IN_A};
            mplier_d = IN_B;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            res_d   = alu_res;
            hi_d    = '0;
            carry_d = alu_carry;
            zero_d  = (alu_res == '0);
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Always WIDTH iterations; the last one publishes the product.
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          res_d   = acc_next[WIDTH-1:0];
          hi_d    = acc_next[2*WIDTH-1:WIDTH];
          carry_d = 1'b0;
          zero_d  = (acc_next == '0);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (OUT_READY) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      hi_q     <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      hi_q     <= hi_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_hs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_seq_hs                                                   |
// | Purpose  : Scoreboard bench for alu_seq_hs. Two instances (WIDTH 8 and 16) |
// |            share clock and reset. Stimulus pushes expected responses into  |
// |            a per-instance queue; a negedge monitor pops and compares on    |
// |            every output handshake and checks latency and hold stability.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_alu_seq_hs;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        c;
    logic        z;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        RESET;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] in_a      [2];
  logic [31:0] in_b      [2];
  logic [3:0]  in_op     [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_res   [2];
  logic [31:0] out_hi    [2];
  logic        out_carry [2];
  logic        out_zero  [2];

  logic [7:0]  res8, hi8;
  logic [15:0] res16, hi16;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Monitor bookkeeping, one slot per instance.
  int          lat     [2];
  bit          lat_run [2];
  bit          seen    [2];
  bit          pv      [2];
  bit          pr      [2];
  logic [66:0] p_out   [2];

  always #5 clk = ~clk;

  alu_seq_hs #(.WIDTH(8)) u8 (
    .CLK(clk), .RESET(RESET),
    .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
    .IN_A(in_a[0][7:0]), .IN_B(in_b[0][7:0]), .ALU_OP_CODE(in_op[0]),
    .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]),
    .OUT_RESULT(res8), .OUT_RESULT_HI(hi8),
    .OUT_CARRY(out_carry[0]), .OUT_ZERO(out_zero[0])
  );

  alu_seq_hs #(.WIDTH(16)) u16 (
    .CLK(clk), .RESET(RESET),
    .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
    .IN_A(in_a[1][15:0]), .IN_B(in_b[1][15:0]), .ALU_OP_CODE(in_op[1]),
    .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]),
    .OUT_RESULT(res16), .OUT_RESULT_HI(hi16),
    .OUT_CARRY(out_carry[1]), .OUT_ZERO(out_zero[1])
  );

  assign out_res[0] = {24'd0, res8};
  assign out_hi[0]  = {24'd0, hi8};
  assign out_res[1] = {16'd0, res16};
  assign out_hi[1]  = {16'd0, hi16};

  // ---------------------------------------------------------------- helpers
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(int d);
    if (d == 0) return q0.size();
    return q1.size();
  endfunction

  function automatic exp_t qfront(int d);
    if (d == 0) return q0[0];
    return q1[0];
  endfunction

  function automatic void qpop(int d);
    if (d == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endfunction

  function automatic void qpush(int d, exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic exp_t mk(logic [31:0] res, logic [31:0] hi, logic c, logic z, int lat_c);
    exp_t e;
    e.res = res; e.hi = hi; e.c = c; e.z = z; e.lat = lat_c;
    return e;
  endfunction

  // Reference model: plain modular arithmetic on w-bit unsigned values.
  function automatic exp_t model(int w, logic [3:0] op, logic [31:0] a_in, logic [31:0] b_in);
    exp_t e;
    longint unsigned m, a, b, r, h, full;
    logic c;
    m = (64'd1 << w) - 64'd1;
    a = 64'(a_in) & m;
    b = 64'(b_in) & m;
    r = 0; h = 0; c = 1'b0; full = 0;
    case (op)
      4'h0: begin full = a + b; r = full & m; c = (full > m); end
      4'h1: begin r = (a - b) & m; c = (a < b); end
      4'h2: begin full = a * b; r = full & m; h = (full >> w) & m; end
      4'h3: begin r = (a * 2) & m; c = (((a >> (w - 1)) & 1) == 1); end
      4'h4: begin r = a / 2; c = ((a % 2) == 1); end
      4'h5: begin r = (a + 1) & m; c = (a == m); end
      4'h6: begin r = (b + 1) & m; c = (b == m); end
      4'h7: begin r = (a - 1) & m; c = (a == 0); end
      4'h8: begin r = (b - 1) & m; c = (b == 0); end
      4'h9: r = (a == b) ? 1 : 0;
      4'hA: r = (a > b) ? 1 : 0;
      4'hB: r = (a < b) ? 1 : 0;
      4'hC: r = a & b;
      4'hD: r = a | b;
      4'hE: r = a ^ b;
      default: r = a;
    endcase
    e.res = 32'(r);
    e.hi  = 32'(h);
    e.c   = c;
    e.z   = (r == 0) && (h == 0);
    e.lat = (op == 4'h2) ? w + 1 : 1;
    return e;
  endfunction

  function automatic logic [31:0] pick(int w);
    logic [31:0] mask;
    mask = 32'((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return mask;
      2:       return 32'd1 << (w - 1);
      3:       return 32'd1;
      default: return $urandom & mask;
    endcase
  endfunction

  // ---------------------------------------------------------------- monitor
  task automatic mon_step(int d);
    exp_t        e;
    logic [66:0] cur;
    cur = {out_valid[d], out_res[d], out_hi[d], out_carry[d], out_zero[d]};
    if (RESET) begin
      lat_run[d] = 1'b0; seen[d] = 1'b0; pv[d] = 1'b0; pr[d] = 1'b0;
      return;
    end
    if (lat_run[d]) lat[d]++;
    if (pv[d] && !pr[d])
      chk($sformatf("hold_stable_u%0d", d), cur, p_out[d]);
    if (out_valid[d] && !seen[d]) begin
      seen[d]    = 1'b1;
      lat_run[d] = 1'b0;
      if (qsize(d) == 0) chk($sformatf("unexpected_valid_u%0d", d), 1, 0);
      else begin
        e = qfront(d);
        chk($sformatf("latency_u%0d", d), lat[d], e.lat);
      end
    end
    if (out_valid[d] && out_ready[d]) begin
      seen[d] = 1'b0;
      if (qsize(d) != 0) begin
        e = qfront(d);
        qpop(d);
        chk($sformatf("result_u%0d", d), out_res[d], e.res);
        chk($sformatf("result_hi_u%0d", d), out_hi[d], e.hi);
        chk($sformatf("carry_u%0d", d), out_carry[d], e.c);
        chk($sformatf("zero_u%0d", d), out_zero[d], e.z);
      end
    end
    pv[d]    = out_valid[d];
    pr[d]    = out_ready[d];
    p_out[d] = cur;
    if (in_valid[d] && in_ready[d]) begin
      lat_run[d] = 1'b1;
      lat[d]     = 0;
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon_step(d);
  end

  // ---------------------------------------------------------------- stimulus
  // All drive tasks start and end at posedge+1.
  task automatic issue(int d, exp_t e, logic [3:0] op, logic [31:0] a, logic [31:0] b);
    int n = 0;
    qpush(d, e);
    in_valid[d] = 1'b1; in_op[d] = op; in_a[d] = a; in_b[d] = b;
    @(negedge clk);
    while (!in_ready[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("accept_u%0d", d), in_ready[d], 1);
    @(posedge clk); #1;
    // Scramble inputs after accept; the captured operation must not change.
    in_valid[d] = 1'b0;
    in_op[d]    = 4'($urandom);
    in_a[d]     = $urandom;
    in_b[d]     = $urandom;
  endtask

  task automatic issue_model(int d, logic [3:0] op, logic [31:0] a, logic [31:0] b);
    issue(d, model((d == 0) ? 8 : 16, op, a, b), op, a, b);
  endtask

  task automatic drain(int d, bit rnd);
    int n = 0;
    while (qsize(d) != 0 && n < 1000) begin
      @(posedge clk); #1;
      if (rnd) out_ready[d] = ($urandom_range(0, 2) != 0);
      n++;
    end
    chk($sformatf("drain_u%0d", d), qsize(d), 0);
  endtask

  task automatic wait_valid(int d);
    int n = 0;
    @(negedge clk);
    while (!out_valid[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("wait_valid_u%0d", d), out_valid[d], 1);
  endtask

  task automatic chk_reset_state(string nm, int d);
    chk($sformatf("%s_u%0d", nm, d),
        {in_ready[d], out_valid[d], out_carry[d], out_zero[d], out_res[d], out_hi[d]},
        {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0});
  endtask

  // Assert reset between edges and check the outputs before any clock edge.
  task automatic mid_reset(string nm);
    #2;
    RESET = 1'b1;
    #1;
    chk_reset_state(nm, 0);
    chk_reset_state(nm, 1);
    q0.delete();
    q1.delete();
    @(negedge clk);
    @(posedge clk); #1;
    RESET = 1'b0;
  endtask

  task automatic expect_no_valid(string nm, int d, int cycles);
    int bad = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (out_valid[d]) bad++;
    end
    chk(nm, bad, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int bad;
    logic [3:0] op;
    RESET = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_a[d] = '0; in_b[d] = '0; in_op[d] = '0;
      out_ready[d] = 1'b1;
    end
    #12;
    chk_reset_state("reset_state", 0);
    chk_reset_state("reset_state", 1);
    @(posedge clk); #1;
    RESET = 1'b0;
    @(posedge clk); #1;

    // Spec vectors, WIDTH=8.
    issue(0, mk(32'h00, 32'h00, 1'b1, 1'b1, 1), 4'h0, 32'hFF, 32'h01);
    drain(0, 1'b0);
    issue(0, mk(32'hFE, 32'h00, 1'b1, 1'b0, 1), 4'h1, 32'h05, 32'h07);
    drain(0, 1'b0);
    issue(0, mk(32'h01, 32'hFE, 1'b0, 1'b0, 9), 4'h2, 32'hFF, 32'hFF);
    bad = 0;
    repeat (9) begin
      @(negedge clk);
      if (in_ready[0]) bad++;
    end
    chk("mul_in_ready_low", bad, 0);
    drain(0, 1'b0);

    // Backpressure: result held 5 cycles while a new request is offered.
    out_ready[0] = 1'b0;
    issue(0, mk(32'h30, 32'h00, 1'b0, 1'b0, 1), 4'hC, 32'hF0, 32'h3C);
    wait_valid(0);
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      in_valid[0] = 1'b1; in_op[0] = 4'h0; in_a[0] = $urandom; in_b[0] = $urandom;
      @(negedge clk);
      if (in_ready[0] || !out_valid[0]) bad++;
    end
    chk("backpressure_hold", bad, 0);
    @(posedge clk); #1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle_after_ready", {in_ready[0], out_valid[0]}, 2'b10);
    @(posedge clk); #1;

    // Abort 3 cycles into a multiply, then a compare must still work.
    issue_model(0, 4'h2, 32'hA7, 32'h5B);
    repeat (2) begin @(posedge clk); #1; end
    mid_reset("reset_mid_mul");
    expect_no_valid("abort_no_valid", 0, 12);
    issue(0, mk(32'h01, 32'h00, 1'b0, 1'b0, 1), 4'h9, 32'h03, 32'h03);
    drain(0, 1'b0);

    // Reset while a result is waiting in DONE.
    out_ready[0] = 1'b0;
    issue_model(0, 4'h0, 32'h12, 32'h34);
    wait_valid(0);
    @(posedge clk); #1;
    mid_reset("reset_in_done");
    out_ready[0] = 1'b1;
    expect_no_valid("done_abort_no_valid", 0, 4);

    // Random sweep: WIDTH=16 over all opcodes, plus a shorter WIDTH=8 run.
    for (int i = 0; i < 320; i++) begin
      op = (i < 32) ? 4'(i % 16) : 4'($urandom_range(0, 15));
      issue_model(1, op, pick(16), pick(16));
      drain(1, 1'b1);
    end
    for (int i = 0; i < 120; i++) begin
      op = 4'($urandom_range(0, 15));
      issue_model(0, op, pick(8), pick(8));
      drain(0, 1'b1);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
